unidade_controle_jogo_escrita: RTL and testbench

// Moore control unit sequencing the memory-game datapath: shows the first stored play, then per round

---
 rtl/unidade_controle_jogo_escrita.sv | 153 +++++++++++++++
 tb/tb_unidade_controle_jogo_escrita.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo_escrita.sv
// Moore control unit for the memory game: shows the first play, checks the player's repetition
// of each round, captures one new play per round and owns the show/inactivity timer.
module unidade_controle_jogo_escrita #(
  parameter int unsigned MOSTRA_CICLOS  = 2000,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned TEMPO_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRodadas,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       registra_jogada,
  output logic       escreve_memoria,
  output logic       mostra_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPreparacao   = 4'h1,
    StMostra       = 4'h2,
    StInicioRodada = 4'h3,
    StEsperaJogada = 4'h4,
    StRegistra     = 4'h5,
    StCompara      = 4'h6,
    StProxJogada   = 4'h7,
    StPrepNova     = 4'h8,
    StEsperaNova   = 4'h9,
    StRegistraNova = 4'hA,
    StEscreve      = 4'hB,
    StProxRodada   = 4'hC,
    StFimGanhou    = 4'hD,
    StFimPerdeu    = 4'hE,
    StFimTimeout   = 4'hF
  } estado_e;

  localparam logic [TEMPO_W-1:0] MostraFim  = TEMPO_W'(MOSTRA_CICLOS - 1);
  localparam logic [TEMPO_W-1:0] TimeoutFim = TEMPO_W'(TIMEOUT_CICLOS - 1);

  estado_e            estado_q, estado_d;
  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic               conta_tempo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= StInicial;
      tempo_q  <= '0;
    end else begin
      estado_q <= estado_d;
      tempo_q  <= tempo_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial:      if (iniciar) estado_d = StPreparacao;
      StPreparacao:   estado_d = StMostra;
      StMostra:       if (tempo_q == MostraFim) estado_d = StInicioRodada;
      StInicioRodada: estado_d = StEsperaJogada;
      // A press on the last allowed cycle still counts as a play.
      StEsperaJogada: begin
        if (tem_jogada)                  estado_d = StRegistra;
        else if (tempo_q == TimeoutFim)  estado_d = StFimTimeout;
      end
      StRegistra:     estado_d = StCompara;
      StCompara: begin
        if (!igual)                    estado_d = StFimPerdeu;
        else if (!enderecoIgualRodada) estado_d = StProxJogada;
        else if (fimRodadas)           estado_d = StFimGanhou;
        else                           estado_d = StPrepNova;
      end
      StProxJogada:   estado_d = StEsperaJogada;
      StPrepNova:     estado_d = StEsperaNova;
      StEsperaNova: begin
        if (tem_jogada)                  estado_d = StRegistraNova;
        else if (tempo_q == TimeoutFim)  estado_d = StFimTimeout;
      end
      StRegistraNova: estado_d = StEscreve;
      StEscreve:      estado_d = StProxRodada;
      StProxRodada:   estado_d = StInicioRodada;
      StFimGanhou, StFimPerdeu, StFimTimeout: begin
        if (iniciar) estado_d = StPreparacao;
      end
      default:        estado_d = StInicial;
    endcase
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_comb begin
    conta_tempo = (estado_q == StMostra) || (estado_q == StEsperaJogada) ||
                  (estado_q == StEsperaNova);
    if (estado_d != estado_q)                  tempo_d = '0;
    else if (conta_tempo && (tempo_q != '1))   tempo_d = tempo_q + 1'b1;
    else                                       tempo_d = tempo_q;
  end

  always_comb begin
    zera_endereco   = 1'b0;
    conta_endereco  = 1'b0;
    zera_rodada     = 1'b0;
    conta_rodada    = 1'b0;
    registra_jogada = 1'b0;
    escreve_memoria = 1'b0;
    mostra_leds     = 1'b0;
    pronto          = 1'b0;
    ganhou          = 1'b0;
    perdeu          = 1'b0;
    db_timeout      = 1'b0;
    case (estado_q)
      StPreparacao: begin
        zera_endereco = 1'b1;
        zera_rodada   = 1'b1;
      end
      StMostra:       mostra_leds     = 1'b1;
      StInicioRodada: zera_endereco   = 1'b1;
      StRegistra:     registra_jogada = 1'b1;
      StProxJogada:   conta_endereco  = 1'b1;
      StPrepNova:     conta_endereco  = 1'b1;
      StRegistraNova: registra_jogada = 1'b1;
      StEscreve:      escreve_memoria = 1'b1;
      StProxRodada:   conta_rodada    = 1'b1;
      StFimGanhou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      StFimPerdeu: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      StFimTimeout: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo_escrita.sv
// Scoreboard bench: each game is planned as a list of player actions, the expected sequence of
// visited states is queued up front, and a monitor pops and checks it on every state change.
module tb_unidade_controle_jogo_escrita;

  localparam int MOSTRA = 2000;
  localparam int TOUT   = 5000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, tem_jogada = 1'b0, igual = 1'b0, eir = 1'b0, fim = 1'b0;
  logic zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra_jogada;
  logic escreve_memoria, mostra_leds, pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  unidade_controle_jogo_escrita #(
    .MOSTRA_CICLOS (MOSTRA),
    .TIMEOUT_CICLOS(TOUT),
    .TEMPO_W       (13)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .iniciar            (iniciar),
    .tem_jogada         (tem_jogada),
    .igual              (igual),
    .enderecoIgualRodada(eir),
    .fimRodadas         (fim),
    .zera_endereco      (zera_endereco),
    .conta_endereco     (conta_endereco),
    .zera_rodada        (zera_rodada),
    .conta_rodada       (conta_rodada),
    .registra_jogada    (registra_jogada),
    .escreve_memoria    (escreve_memoria),
    .mostra_leds        (mostra_leds),
    .pronto             (pronto),
    .ganhou             (ganhou),
    .perdeu             (perdeu),
    .db_timeout         (db_timeout),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {int code; int dwell;} exp_t;
  typedef struct {int wcode; int k; bit igual; bit eir; bit fim; bit rst;} act_t;

  exp_t exp_q[$];
  act_t act_q[$];
  int   tests = 0;
  int   fails = 0;
  int   esc_count = 0;
  int   exp_writes = 0;
  int   final_code = 0;
  bit   mon_en = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit order: zera_end conta_end zera_rod conta_rod registra escreve mostra pronto ganhou perdeu tout
  function automatic logic [10:0] tabela(input int code);
    case (code)
      1:       return 11'b101_0000_0000;
      2:       return 11'b000_0001_0000;
      3:       return 11'b100_0000_0000;
      5, 10:   return 11'b000_0100_0000;
      7, 8:    return 11'b010_0000_0000;
      11:      return 11'b000_0010_0000;
      12:      return 11'b000_1000_0000;
      13:      return 11'b000_0000_1100;
      14:      return 11'b000_0000_1010;
      15:      return 11'b000_0000_1011;
      default: return 11'b000_0000_0000;
    endcase
  endfunction

  function automatic logic [10:0] saidas();
    return {zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra_jogada,
            escreve_memoria, mostra_leds, pronto, ganhou, perdeu, db_timeout};
  endfunction

  function automatic void push(input int code, input int dwell);
    exp_t e;
    e.code  = code;
    e.dwell = dwell;
    exp_q.push_back(e);
  endfunction

  function automatic void act(input int wcode, input int k, input bit ig, input bit ei,
                              input bit fi, input bit rst);
    act_t a;
    a.wcode = wcode; a.k = k; a.igual = ig; a.eir = ei; a.fim = fi; a.rst = rst;
    act_q.push_back(a);
  endfunction

  // Game model. mode 0 win, 1 wrong play, 2 timeout waiting for the new play,
  // 3 timeout while repeating, 4 reset while repeating. long_r: round whose new play
  // arrives on the very last allowed cycle.
  task automatic plan_game(input int mode, input int stop_r, input int long_r);
    int  k;
    bit  hit;
    exp_writes = 0;
    push(1, 1); push(2, MOSTRA); push(3, 1);
    for (int r = 0; r < 16; r++) begin
      for (int a = 0; a <= r; a++) begin
        hit = (r == stop_r) && (a == stop_r / 2);
        if (hit && mode == 3) begin
          push(4, TOUT); push(15, 0); act(4, 0, 1'b1, 1'b0, 1'b0, 1'b0);
          final_code = 15; return;
        end
        if (hit && mode == 4) begin
          push(4, 0); push(0, 0); act(4, $urandom_range(1, 20), 1'b1, 1'b0, 1'b0, 1'b1);
          final_code = 0; return;
        end
        k = $urandom_range(1, 4);
        push(4, k); push(5, 1); push(6, 1);
        act(4, k, !(hit && mode == 1), a == r, r == 15, 1'b0);
        if (hit && mode == 1) begin
          push(14, 0); final_code = 14; return;
        end
        if (a < r)        push(7, 1);
        else if (r == 15) begin push(13, 0); final_code = 13; return; end
        else              push(8, 1);
      end
      if (mode == 2 && r == stop_r) begin
        push(9, TOUT); push(15, 0); act(9, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        final_code = 15; return;
      end
      k = (r == long_r) ? TOUT : $urandom_range(1, 4);
      push(9, k); push(10, 1); push(11, 1); push(12, 1); push(3, 1);
      act(9, k, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b0);
      exp_writes++;
    end
  endtask

  task automatic wait_state(input int code, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (int'(db_estado) == code) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(ok, "espera_estado", int'(db_estado), code);
  endtask

  task automatic pulse(input int k);
    repeat (k - 1) @(negedge clock);
    tem_jogada = 1'b1;
    @(negedge clock);
    tem_jogada = 1'b0;
  endtask

  task automatic play(input int mode, input int stop_r, input int long_r, input bit hold);
    act_t a;
    bit   ok;
    int   w0;
    plan_game(mode, stop_r, long_r);
    w0 = esc_count;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = hold;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      wait_state(a.wcode, ok);
      if (!ok) begin
        act_q.delete();
        break;
      end
      igual = a.igual; eir = a.eir; fim = a.fim;
      if (a.rst) begin
        repeat (a.k) @(negedge clock);
        iniciar = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
      end else if (a.k > 0) begin
        pulse(a.k);
      end
    end
    wait_state(final_code, ok);
    @(negedge clock);
    check(esc_count - w0 == exp_writes, "escritas", esc_count - w0, exp_writes);
    check(exp_q.size() == 0, "fila_pendente", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: on each state change, close out the old state's dwell and check the new one.
  initial begin
    int          prev;
    int          cnt;
    exp_t        cur;
    exp_t        e;
    logic [10:0] o;
    prev = 0; cnt = 0; cur.code = 0; cur.dwell = 0;
    wait (mon_en);
    forever begin
      @(negedge clock);
      if (escreve_memoria) esc_count++;
      if (int'(db_estado) != prev) begin
        if (cur.dwell != 0) check(cnt == cur.dwell, "permanencia", cnt, cur.dwell);
        check(exp_q.size() != 0, "estado_inesperado", int'(db_estado), prev);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          o = saidas();
          check(int'(db_estado) == e.code, "estado", int'(db_estado), e.code);
          check(o == tabela(e.code), "saidas", int'(o), int'(tabela(e.code)));
        end else begin
          e.code = int'(db_estado);
          e.dwell = 0;
        end
        cur  = e;
        prev = int'(db_estado);
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached, estado %0h", db_estado);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check(db_estado == 4'h0, "reset_estado", int'(db_estado), 0);
    check(saidas() == 11'd0, "reset_saidas", int'(saidas()), 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clock);
    check(db_estado == 4'h0, "inicial_parado", int'(db_estado), 0);

    play(0, 0, -1, 1'b0);
    check(ganhou && pronto && !perdeu, "ganhou_flags", int'(saidas()), int'(tabela(13)));
    play(1, 3, -1, 1'b0);
    play(2, 1, -1, 1'b0);
    check(db_timeout && perdeu, "timeout_flags", int'(saidas()), int'(tabela(15)));
    play(4, 2, 0, 1'b1);
    check(saidas() == 11'd0, "reset_meio_jogo", int'(saidas()), 0);
    play(3, $urandom_range(1, 3), -1, 1'b0);
    play(1, $urandom_range(0, 2), -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
